// File: rtl/half_fp_pkg.sv
// Shared binary16 constants, FSM state encoding and the leading-zero helper
// used by the half-precision add/subtract unit.
package half_fp_pkg;

  localparam int          EXP_W   = 5;
  localparam int          MANT_W  = 10;
  localparam logic [4:0]  EXP_MAX = 5'h1F;
  localparam int          BIAS    = 15;
  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam int          EXT_W   = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_e;

  // Returns 14 for an all-zero input.
  function automatic logic [3:0] lzc14(input logic [EXT_W-1:0] v);
    logic [3:0] n;
    logic       found;
    n     = 4'd14;
    found = 1'b0;
    for (int i = EXT_W - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 4'(EXT_W - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/half_special_detect.sv
// Resolves NaN / infinity / zero operand combinations for binary16 add/sub.
// is_special marks that special_q is the final result.
module half_special_detect
  import half_fp_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sb,
  output logic        is_special,
  output logic [15:0] special_q
);

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic unused_b_sign;

  assign unused_b_sign = b[15];
  assign a_nan  = (a[14:10] == EXP_MAX) && (a[9:0] != '0);
  assign b_nan  = (b[14:10] == EXP_MAX) && (b[9:0] != '0);
  assign a_inf  = (a[14:10] == EXP_MAX) && (a[9:0] == '0);
  assign b_inf  = (b[14:10] == EXP_MAX) && (b[9:0] == '0);
  assign a_zero = (a[14:0] == '0);
  assign b_zero = (b[14:0] == '0);

  always_comb begin
    is_special = 1'b1;
    special_q  = QNAN;
    if (a_nan || b_nan) begin
      special_q = QNAN;
    end else if (a_inf && b_inf && (a[15] != sb)) begin
      special_q = QNAN;
    end else if (a_inf) begin
      special_q = a;
    end else if (b_inf) begin
      special_q = {sb, b[14:0]};
    end else if (a_zero && !b_zero) begin
      special_q = {sb, b[14:0]};
    end else if (b_zero && !a_zero) begin
      special_q = a;
    end else if (a_zero && b_zero) begin
      special_q = {a[15] & sb, 15'd0};
    end else begin
      is_special = 1'b0;
    end
  end

endmodule

// File: rtl/half_addsub_seq.sv
// Multi-cycle binary16 add/subtract: special-case check, then align, add,
// normalize and round-to-nearest-even, with valid/ready on both sides.
module half_addsub_seq
  import half_fp_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        OP,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] Q,
  output logic        EXC,
  output logic        OVF
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds its payload stable until that edge.
  state_e            state_q, state_d;
  logic [15:0]       a_q, a_d, b_q, b_d, q_q, q_d;
  logic              op_q, op_d, sign_q, sign_d, sub_q, sub_d, zero_q, zero_d;
  logic [EXT_W-1:0]  big_q, big_d, small_q, small_d, m_q, m_d;
  logic [EXT_W:0]    sum_q, sum_d;
  logic [5:0]        exp_q, exp_d;
  logic              exc_q, exc_d, ovf_q, ovf_d, out_valid_q, out_valid_d;

  logic              sb, is_special;
  logic [15:0]       special_res;

  assign sb = b_q[15] ^ op_q;

  half_special_detect u_special (
    .a          (a_q),
    .b          (b_q),
    .sb         (sb),
    .is_special (is_special),
    .special_q  (special_res)
  );

  // Alignment: larger magnitude first, smaller shifted with sticky collection.
  logic              a_first;
  logic [10:0]       big_sig, small_sig;
  logic [4:0]        big_e, small_e, diff;
  logic [EXT_W-1:0]  small_ext, lost, al_small;

  always_comb begin
    a_first = (a_q[14:0] >= b_q[14:0]);
    if (a_first) begin
      big_sig   = {|a_q[14:10], a_q[9:0]};
      big_e     = (a_q[14:10] == '0) ? 5'd1 : a_q[14:10];
      small_sig = {|b_q[14:10], b_q[9:0]};
      small_e   = (b_q[14:10] == '0) ? 5'd1 : b_q[14:10];
    end else begin
      big_sig   = {|b_q[14:10], b_q[9:0]};
      big_e     = (b_q[14:10] == '0) ? 5'd1 : b_q[14:10];
      small_sig = {|a_q[14:10], a_q[9:0]};
      small_e   = (a_q[14:10] == '0) ? 5'd1 : a_q[14:10];
    end
    diff      = big_e - small_e;
    small_ext = {small_sig, 3'b000};
    lost      = '0;
    if (diff >= 5'd14) begin
      al_small = {13'd0, |small_ext};
    end else begin
      al_small    = small_ext >> diff;
      lost        = small_ext & ~(14'h3FFF << diff);
      al_small[0] = al_small[0] | (|lost);
    end
  end

  logic [3:0]        lz;
  logic [5:0]        max_sh, sh, n_e;
  logic [EXT_W-1:0]  n_m;
  logic              n_zero;

  always_comb begin
    lz     = lzc14(sum_q[EXT_W-1:0]);
    max_sh = exp_q - 6'd1;
    sh     = ({2'b00, lz} > max_sh) ? max_sh : {2'b00, lz};
    n_zero = 1'b0;
    n_m    = sum_q[EXT_W-1:0] << sh;
    n_e    = exp_q - sh;
    if (sum_q[EXT_W]) begin
      n_m = {sum_q[14:2], sum_q[1] | sum_q[0]};
      n_e = exp_q + 6'd1;
    end else if (sum_q == '0) begin
      n_zero = 1'b1;
      n_m    = '0;
      n_e    = exp_q;
    end
  end

  logic              rnd_up, hidden, r_ovf;
  logic [11:0]       r12;
  logic [9:0]        frac;
  logic [5:0]        r_e;
  logic [15:0]       r_q;

  always_comb begin
    rnd_up = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    r12    = {1'b0, m_q[13:3]} + {11'd0, rnd_up};
    if (r12[11]) begin
      frac   = r12[10:1];
      r_e    = exp_q + 6'd1;
      hidden = 1'b1;
    end else begin
      frac   = r12[9:0];
      r_e    = exp_q;
      hidden = r12[10];
    end
    r_ovf = 1'b0;
    r_q   = {sign_q, hidden ? r_e[4:0] : 5'd0, frac};
    if (zero_q) begin
      r_q = 16'h0000;
    end else if (r_e >= 6'd31) begin
      r_q   = {sign_q, EXP_MAX, 10'd0};
      r_ovf = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    big_d       = big_q;
    small_d     = small_q;
    sum_d       = sum_q;
    m_d         = m_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    sub_d       = sub_q;
    zero_d      = zero_q;
    q_d         = q_q;
    exc_d       = exc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          a_d     = A;
          b_d     = B;
          op_d    = OP;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (is_special) begin
          q_d         = special_res;
          exc_d       = 1'b1;
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        big_d   = {big_sig, 3'b000};
        small_d = al_small;
        exp_d   = {1'b0, big_e};
        sign_d  = a_first ? a_q[15] : sb;
        sub_d   = a_q[15] ^ sb;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                        : ({1'b0, big_q} + {1'b0, small_q});
        state_d = ST_NORM;
      end
      ST_NORM: begin
        m_d     = n_m;
        exp_d   = n_e;
        zero_d  = n_zero;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        q_d         = r_q;
        exc_d       = 1'b0;
        ovf_d       = r_ovf;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      big_q       <= '0;
      small_q     <= '0;
      sum_q       <= '0;
      m_q         <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      zero_q      <= 1'b0;
      q_q         <= '0;
      exc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      big_q       <= big_d;
      small_q     <= small_d;
      sum_q       <= sum_d;
      m_q         <= m_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      zero_q      <= zero_d;
      q_q         <= q_d;
      exc_q       <= exc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY  = (state_q == ST_IDLE) && !RST;
  assign OUT_VALID = out_valid_q;
  assign Q         = q_q;
  assign EXC       = exc_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_half_addsub_seq.sv
// Bench for half_addsub_seq: directed and random operands scored against an
// exact-integer binary16 reference model through an expected-result queue.
module tb_half_addsub_seq;

  localparam int W = 21;  // {q[15:0], exc, ovf, latency[2:0]}

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID, IN_READY, OP, OUT_VALID, OUT_READY, EXC, OVF;
  logic [15:0] A, B, Q;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] held;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  logic prev_valid = 1'b0;

  half_addsub_seq dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Q         (Q),
    .EXC       (EXC),
    .OVF       (OVF)
  );

  // Clock / reset
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: exact value in units of 2^-24, rounded to nearest even.
  function automatic longint mag16(input logic [15:0] x);
    if (x[14:10] == 5'd0) return longint'(x[9:0]);
    return longint'({1'b1, x[9:0]}) << (x[14:10] - 1);
  endfunction

  function automatic logic [W-1:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic op);
    logic sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn, ovf;
    longint va, vb, s, m, qm, rem, half;
    int p, k, e;
    logic [15:0] r;
    sb     = b[15] ^ op;
    a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 0);
    a_zero = (a[14:0] == 0);
    b_zero = (b[14:0] == 0);
    if (a_nan || b_nan) return {16'h7E00, 2'b10, 3'd2};
    if (a_inf && b_inf && (a[15] != sb)) return {16'h7E00, 2'b10, 3'd2};
    if (a_inf) return {a, 2'b10, 3'd2};
    if (b_inf) return {sb, b[14:0], 2'b10, 3'd2};
    if (a_zero && !b_zero) return {sb, b[14:0], 2'b10, 3'd2};
    if (b_zero && !a_zero) return {a, 2'b10, 3'd2};
    if (a_zero && b_zero) return {a[15] & sb, 15'd0, 2'b10, 3'd2};
    va = mag16(a);
    vb = mag16(b);
    s  = (a[15] ? -va : va) + (sb ? -vb : vb);
    if (s == 0) return {16'h0000, 2'b00, 3'd6};
    sgn = (s < 0);
    m   = sgn ? -s : s;
    ovf = 1'b0;
    if (m < 2048) begin
      r = {sgn, 15'(m)};
    end else begin
      p = 0;
      for (int i = 0; i < 48; i++) if ((m >> i) != 0) p = i;
      k    = p - 10;
      qm   = m >> k;
      rem  = m - (qm << k);
      half = longint'(1) << (k - 1);
      if (rem > half || (rem == half && qm[0])) qm++;
      if (qm == 2048) begin
        qm = 1024;
        k++;
      end
      e = k + 1;
      if (e >= 31) begin
        r   = {sgn, 15'h7C00};
        ovf = 1'b1;
      end else begin
        r = {sgn, 5'(e), 10'(qm - 1024)};
      end
    end
    return {r, 1'b0, ovf, 3'd6};
  endfunction

  // Monitor / scoreboard
  always @(negedge CLK) begin
    if (RST) begin
      prev_valid = 1'b0;
    end else begin
      if (IN_VALID && IN_READY) accept_cyc = cyc;
      if (OUT_VALID && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=Q %h expected=no result", Q);
        end else begin
          held = exp_q.pop_front();
          chk("q", 32'(Q), 32'(held[20:5]));
          chk("exc", 32'(EXC), 32'(held[4]));
          chk("ovf", 32'(OVF), 32'(held[3]));
          chk("latency", 32'(cyc - accept_cyc), 32'(held[2:0]));
        end
      end else if (OUT_VALID && prev_valid) begin
        chk("hold_q", 32'(Q), 32'(held[20:5]));
        chk("hold_in_ready", 32'(IN_READY), 32'd0);
      end
      prev_valid = OUT_VALID;
    end
  end

  // Driver: called and returns just after a rising edge.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic op,
                         input int hold);
    int n;
    A = a;
    B = b;
    OP = op;
    IN_VALID = 1'b1;
    n = 0;
    while (!IN_READY && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!IN_READY) begin
      chk("accept_timeout", 32'(IN_READY), 32'd1);
      IN_VALID = 1'b0;
      return;
    end
    exp_q.push_back(ref_model(a, b, op));
    @(posedge CLK); #1;
    A = 16'($urandom);
    B = 16'($urandom);
    OP = 1'($urandom);
    n = 0;
    while (!OUT_VALID && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    IN_VALID = 1'b0;
    if (!OUT_VALID) begin
      chk("result_timeout", 32'(OUT_VALID), 32'd1);
      exp_q.delete();
      return;
    end
    repeat (hold) begin
      @(posedge CLK); #1;
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
  endtask

  task automatic reset_during_add();
    int n;
    A = 16'h3C00;
    B = 16'h3C00;
    OP = 1'b0;
    IN_VALID = 1'b1;
    n = 0;
    while (!IN_READY && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_mid_in_ready", 32'(IN_READY), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(IN_READY), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chk("post_rst_out_valid", 32'(OUT_VALID), 32'd0);
    end
  endtask

  logic [15:0] dir_a  [10] = '{16'h3C00, 16'h3C00, 16'h8000, 16'h7C00, 16'h7E01,
                               16'h7BFF, 16'h3C01, 16'h3C00, 16'h0001, 16'h3C00};
  logic [15:0] dir_b  [10] = '{16'h3C00, 16'h3C00, 16'h8000, 16'h7C00, 16'h3C00,
                               16'h7BFF, 16'h1000, 16'h1000, 16'h0001, 16'h4000};
  logic        dir_op [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int          dir_h  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5};

  initial begin
    logic [15:0] ra, rb;
    int sel, n;
    RST = 1'b1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    A = '0;
    B = '0;
    OP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_in_ready", 32'(IN_READY), 32'd0);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_exc", 32'(EXC), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    RST = 1'b0;
    #1;
    chk("rel_in_ready", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;

    for (int i = 0; i < 10; i++) run_txn(dir_a[i], dir_b[i], dir_op[i], dir_h[i]);

    reset_during_add();
    run_txn(16'h3C00, 16'h3C00, 1'b0, 0);

    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 3);
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (sel == 1) rb[14:10] = ra[14:10] ^ 5'($urandom_range(0, 1));
      if (sel == 2) begin
        ra[14:10] = 5'($urandom_range(0, 2));
        rb[14:10] = 5'($urandom_range(0, 2));
      end
      if (sel == 3) begin
        ra[14:10] = 5'($urandom_range(26, 30));
        rb[14:10] = 5'($urandom_range(26, 30));
      end
      run_txn(ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge CLK);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
